fcvrt_int2fp_pipe: RTL and testbench

- Pipelined integer-to-float converter for the FPU. Covers fcvt.s.w and fcvt.s.wu, with a parametrised integer width and float format.
- Applies the requested rounding mode and reports inexact.
- Three pipeline stages with valid/ready handshakes on both sides. Sits between the FPU issue stage and the FP writeback arbiter.

---
 rtl/fcvrt_int2fp_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_fcvrt_int2fp_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcvrt_int2fp_pipe.sv
// Three-stage integer-to-float converter (fcvt.s.w / fcvt.s.wu) with rounding and inexact flag.
// Stages: sign/magnitude, normalise, round/pack; elastic valid/ready handshake on both ends.
module fcvrt_int2fp_pipe #(
  parameter int unsigned INT_W = 32,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INT_W-1:0]           in_int,
  input  logic                       in_signed,
  input  logic [2:0]                 in_rm,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out_fp,
  output logic                       out_nx,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int unsigned FP_W   = 1 + EXP_W + MAN_W;
  localparam int unsigned FRAC_W = INT_W - 1;
  localparam int unsigned LZ_W   = $clog2(INT_W);
  // Fraction plus zero padding so G and S always exist, even when INT_W-1 <= MAN_W.
  localparam int unsigned EXT_W  = FRAC_W + MAN_W + 2;
  localparam logic [EXP_W-1:0] BIAS = EXP_W'((1 << (EXP_W - 1)) - 1);

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Stage registers
  logic                s1_valid_q, s1_valid_d;
  logic                s1_sign_q, s1_sign_d;
  logic [INT_W-1:0]    s1_mag_q, s1_mag_d;
  logic                s1_zero_q, s1_zero_d;
  logic [2:0]          s1_rm_q, s1_rm_d;
  logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;

  logic                s2_valid_q, s2_valid_d;
  logic [FRAC_W-1:0]   s2_frac_q, s2_frac_d;
  logic [EXP_W-1:0]    s2_exp_q, s2_exp_d;
  logic                s2_sign_q, s2_sign_d;
  logic                s2_zero_q, s2_zero_d;
  logic [2:0]          s2_rm_q, s2_rm_d;
  logic [TAG_W-1:0]    s2_tag_q, s2_tag_d;

  logic                s3_valid_q, s3_valid_d;
  logic [FP_W-1:0]     s3_fp_q, s3_fp_d;
  logic                s3_nx_q, s3_nx_d;
  logic [TAG_W-1:0]    s3_tag_q, s3_tag_d;

  // Handshake chain
  logic s3_ready, s2_ready, s2_adv, s1_adv, in_fire;

  always_comb begin
    s3_ready = !s3_valid_q || out_ready;
    s2_ready = !s2_valid_q || s3_ready;
    s2_adv   = s2_valid_q && s3_ready;
    s1_adv   = s1_valid_q && s2_ready;
    in_ready = !rst && (!s1_valid_q || s1_adv);
    in_fire  = in_valid && in_ready;
  end

  // S1: sign and magnitude
  logic             sign_c;
  logic [INT_W-1:0] mag_c;

  always_comb begin
    sign_c = in_signed & in_int[INT_W-1];
    mag_c  = sign_c ? ({INT_W{1'b0}} - in_int) : in_int;

    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s1_zero_d  = s1_zero_q;
    s1_rm_d    = s1_rm_q;
    s1_tag_d   = s1_tag_q;
    if (!s1_valid_q || s1_adv) s1_valid_d = in_fire;
    if (in_fire) begin
      s1_sign_d = sign_c;
      s1_mag_d  = mag_c;
      s1_zero_d = (mag_c == '0);
      s1_rm_d   = in_rm;
      s1_tag_d  = in_tag;
    end
  end

  // S2: leading-zero count and normalise
  logic [LZ_W-1:0] lz_c;

  always_comb begin
    lz_c = '0;
    // Scan upward so the highest set bit wins.
    for (int i = 0; i < int'(INT_W); i++) begin
      if (s1_mag_q[i]) lz_c = LZ_W'(int'(INT_W) - 1 - i);
    end

    s2_valid_d = s2_valid_q;
    s2_frac_d  = s2_frac_q;
    s2_exp_d   = s2_exp_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_rm_d    = s2_rm_q;
    s2_tag_d   = s2_tag_q;
    if (s2_ready) s2_valid_d = s1_valid_q;
    if (s1_adv) begin
      // Hidden bit is dropped here; it is implied by a nonzero operand.
      s2_frac_d = FRAC_W'(s1_mag_q << lz_c);
      s2_exp_d  = EXP_W'(INT_W - 1) - EXP_W'(lz_c);
      s2_sign_d = s1_sign_q;
      s2_zero_d = s1_zero_q;
      s2_rm_d   = s1_rm_q;
      s2_tag_d  = s1_tag_q;
    end
  end

  // S3: round and pack
  logic [EXT_W-1:0] ext_c;
  logic [MAN_W-1:0] kept_c;
  logic             g_c, s_c, l_c, nx_c, inc_c;
  logic [MAN_W:0]   sum_c;
  logic [EXP_W-1:0] bexp_c;

  always_comb begin
    ext_c  = {s2_frac_q, {(MAN_W + 2){1'b0}}};
    kept_c = ext_c[EXT_W-1 -: MAN_W];
    g_c    = ext_c[EXT_W-1-MAN_W];
    s_c    = |ext_c[EXT_W-2-MAN_W:0];
    l_c    = kept_c[0];
    nx_c   = g_c | s_c;
    case (s2_rm_q)
      RM_RTZ:  inc_c = 1'b0;
      RM_RDN:  inc_c = s2_sign_q & nx_c;
      RM_RUP:  inc_c = !s2_sign_q & nx_c;
      RM_RMM:  inc_c = g_c;
      default: inc_c = g_c & (s_c | l_c);
    endcase
    sum_c  = {1'b0, kept_c} + {{MAN_W{1'b0}}, inc_c};
    // Mantissa carry-out leaves the low bits zero and bumps the exponent.
    bexp_c = s2_exp_q + BIAS + {{(EXP_W - 1){1'b0}}, sum_c[MAN_W]};

    s3_valid_d = s3_valid_q;
    s3_fp_d    = s3_fp_q;
    s3_nx_d    = s3_nx_q;
    s3_tag_d   = s3_tag_q;
    if (s3_ready) s3_valid_d = s2_valid_q;
    if (s2_adv) begin
      s3_fp_d  = s2_zero_q ? '0 : {s2_sign_q, bexp_c, sum_c[MAN_W-1:0]};
      s3_nx_d  = s2_zero_q ? 1'b0 : nx_c;
      s3_tag_d = s2_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_rm_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_frac_q  <= '0;
      s2_exp_q   <= '0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_rm_q    <= '0;
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_fp_q    <= '0;
      s3_nx_q    <= 1'b0;
      s3_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s1_zero_q  <= s1_zero_d;
      s1_rm_q    <= s1_rm_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_frac_q  <= s2_frac_d;
      s2_exp_q   <= s2_exp_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_rm_q    <= s2_rm_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      s3_fp_q    <= s3_fp_d;
      s3_nx_q    <= s3_nx_d;
      s3_tag_q   <= s3_tag_d;
    end
  end

  always_comb begin
    out_valid = s3_valid_q;
    out_fp    = s3_fp_q;
    out_nx    = s3_nx_q;
    out_tag   = s3_tag_q;
  end

endmodule

// File: tb/tb_fcvrt_int2fp_pipe.sv
// Bench for fcvrt_int2fp_pipe: arithmetic reference model plus scoreboard, directed and random ops.
module tb_fcvrt_int2fp_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_nx;
  logic [31:0] in_int, out_fp;
  logic [2:0]  in_rm;
  logic [4:0]  in_tag, out_tag;

  // 64-bit instance
  logic        in_valid_w, in_ready_w, in_signed_w, out_valid_w, out_ready_w, out_nx_w;
  logic [63:0] in_int_w;
  logic [31:0] out_fp_w;
  logic [2:0]  in_rm_w;
  logic [4:0]  in_tag_w, out_tag_w;

  fcvrt_int2fp_pipe #(.INT_W(32), .EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_int(in_int),
    .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_fp(out_fp), .out_nx(out_nx), .out_tag(out_tag)
  );

  fcvrt_int2fp_pipe #(.INT_W(64), .EXP_W(8), .MAN_W(23), .TAG_W(5)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w), .in_int(in_int_w),
    .in_signed(in_signed_w), .in_rm(in_rm_w), .in_tag(in_tag_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .out_fp(out_fp_w), .out_nx(out_nx_w), .out_tag(out_tag_w)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_pop = 0;
  bit lat_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: locate the MSB, then decide rounding by comparing the remainder with half an ulp.
  function automatic void model(input logic [63:0] v_in, input bit sgn, input logic [2:0] rm,
                                input int iw, output logic [31:0] fp, output logic nx);
    logic [63:0] mask, v, m, q, rem, half;
    bit neg, incr;
    int p, sh;
    logic [7:0] be;
    mask = (iw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << iw) - 64'd1);
    v = v_in & mask;
    neg = sgn && v[iw-1];
    m = neg ? ((~v + 64'd1) & mask) : v;
    fp = '0;
    nx = 1'b0;
    if (m == 64'd0) return;
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh = p - 23;
      q = m >> sh;
      rem = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      nx = (rem != 64'd0);
      case (rm)
        3'd1: incr = 1'b0;
        3'd2: incr = neg && nx;
        3'd3: incr = !neg && nx;
        3'd4: incr = (rem >= half);
        default: incr = (rem > half) || (rem == half && q[0]);
      endcase
      q = q + {63'd0, incr};
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    be = 8'(p + 127);
    fp = {neg, be, q[22:0]};
  endfunction

  typedef struct {
    logic [31:0] fp;
    logic        nx;
    logic [4:0]  tag;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic [31:0] m_fp;
  logic        m_nx;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_fp;
  logic        prev_nx;
  logic [4:0]  prev_tag;

  // Compare process: samples on the falling edge, so values seen are those at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      stall_prev = 1'b0;
      check("in_ready_during_rst", {63'd0, in_ready}, 64'd0);
    end else begin
      if (stall_prev) begin
        check("stall_valid_held", {63'd0, out_valid}, 64'd1);
        check("stall_fp_held", {32'd0, out_fp}, {32'd0, prev_fp});
        check("stall_tag_held", {59'd0, out_tag}, {59'd0, prev_tag});
        check("stall_nx_held", {63'd0, out_nx}, {63'd0, prev_nx});
      end
      if (!in_ready) check("occupancy_when_full", 64'(sbq.size()), 64'd3);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_result_tag", {59'd0, out_tag}, 64'hFFFF);
        end else begin
          mon_e = sbq.pop_front();
          n_pop++;
          check("result_fp", {32'd0, out_fp}, {32'd0, mon_e.fp});
          check("result_nx", {63'd0, out_nx}, {63'd0, mon_e.nx});
          check("result_tag", {59'd0, out_tag}, {59'd0, mon_e.tag});
          if (mon_e.chk_lat) check("latency", 64'(cyc - mon_e.cyc), 64'd3);
        end
      end
      if (in_valid && in_ready) begin
        model({32'd0, in_int}, in_signed, in_rm, 32, m_fp, m_nx);
        sbq.push_back('{fp: m_fp, nx: m_nx, tag: in_tag, cyc: cyc, chk_lat: lat_mode});
      end
      stall_prev = out_valid && !out_ready;
      prev_fp  = out_fp;
      prev_nx  = out_nx;
      prev_tag = out_tag;
    end
  end

  // Called just after a rising edge; returns just after the edge on which the op transferred.
  task automatic send(input logic [31:0] v, input bit sgn, input logic [2:0] rm,
                      input logic [4:0] tag);
    int w;
    in_int = v;
    in_signed = sgn;
    in_rm = rm;
    in_tag = tag;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_lit(input logic [31:0] v, input bit sgn, input logic [2:0] rm,
                          input logic [4:0] tag, input logic [31:0] lit_fp, input logic lit_nx);
    logic [31:0] f;
    logic n;
    model({32'd0, v}, sgn, rm, 32, f, n);
    check("model_pin_fp", {32'd0, f}, {32'd0, lit_fp});
    check("model_pin_nx", {63'd0, n}, {63'd0, lit_nx});
    send(v, sgn, rm, tag);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic w64(input logic [63:0] v, input bit sgn, input logic [2:0] rm,
                     input logic [31:0] lit_fp, input logic lit_nx);
    logic [31:0] f;
    logic n;
    int cnt;
    model(v, sgn, rm, 64, f, n);
    check("w64_model_pin_fp", {32'd0, f}, {32'd0, lit_fp});
    in_int_w = v;
    in_signed_w = sgn;
    in_rm_w = rm;
    in_tag_w = 5'd9;
    in_valid_w = 1'b1;
    @(negedge clk);
    check("w64_in_ready", {63'd0, in_ready_w}, 64'd1);
    @(posedge clk);
    #1;
    in_valid_w = 1'b0;
    cnt = 1;
    @(negedge clk);
    while (!out_valid_w && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("w64_latency", 64'(cnt), 64'd3);
    check("w64_fp", {32'd0, out_fp_w}, {32'd0, f});
    check("w64_nx", {63'd0, out_nx_w}, {63'd0, n});
    check("w64_tag", {59'd0, out_tag_w}, 64'd9);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pops0, c0;
    rst = 1'b1;
    in_valid = 1'b0; in_int = '0; in_signed = 1'b0; in_rm = '0; in_tag = '0; out_ready = 1'b1;
    in_valid_w = 1'b0; in_int_w = '0; in_signed_w = 1'b0; in_rm_w = '0; in_tag_w = '0;
    out_ready_w = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_fp", {32'd0, out_fp}, 64'd0);
    check("reset_out_nx", {63'd0, out_nx}, 64'd0);
    check("reset_out_tag", {59'd0, out_tag}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_w_out_valid", {63'd0, out_valid_w}, 64'd0);
    @(posedge clk);
    #1;

    // Directed, latency-checked, out_ready held high
    lat_mode = 1'b1;
    for (int r = 0; r < 8; r++) send_lit(32'h0, 1'b1, 3'(r), 5'(r), 32'h0, 1'b0);
    send_lit(32'hFFFF_FFFF, 1'b0, 3'd0, 5'd8,  32'h4F80_0000, 1'b1);
    send_lit(32'hFFFF_FFFF, 1'b0, 3'd1, 5'd9,  32'h4F7F_FFFF, 1'b1);
    send_lit(32'hFFFF_FFFF, 1'b1, 3'd0, 5'd10, 32'hBF80_0000, 1'b0);
    send_lit(32'h8000_0000, 1'b1, 3'd0, 5'd11, 32'hCF00_0000, 1'b0);
    send_lit(32'h8000_0000, 1'b0, 3'd0, 5'd12, 32'h4F00_0000, 1'b0);
    send_lit(32'h0100_0001, 1'b1, 3'd0, 5'd13, 32'h4B80_0000, 1'b1);
    send_lit(32'h0100_0001, 1'b1, 3'd4, 5'd14, 32'h4B80_0001, 1'b1);
    send_lit(32'h0100_0001, 1'b1, 3'd3, 5'd15, 32'h4B80_0001, 1'b1);
    send_lit(32'h0100_0001, 1'b1, 3'd2, 5'd16, 32'h4B80_0000, 1'b1);
    send_lit(32'hFEFF_FFFF, 1'b1, 3'd2, 5'd17, 32'hCB80_0001, 1'b1);
    drain();

    // Backpressure: 6 back-to-back ops, out_ready low for cycles 2..8
    lat_mode = 1'b0;
    pops0 = n_pop;
    fork
      begin
        for (int t = 1; t <= 6; t++) send($urandom, 1'($urandom), 3'($urandom_range(0, 4)), 5'(t));
      end
      begin
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("backpressure_count", 64'(n_pop - pops0), 64'd6);

    // Random, one op per cycle
    lat_mode = 1'b1;
    pops0 = n_pop;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      send($urandom >> $urandom_range(0, 31), 1'($urandom), 3'($urandom_range(0, 7)), 5'(i));
    end
    check("throughput_cycles", 64'(cyc - c0), 64'd100);
    drain();
    check("random_count", 64'(n_pop - pops0), 64'd100);

    // Reset with all three stages occupied
    lat_mode = 1'b0;
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) send($urandom, 1'b0, 3'd0, 5'(20 + t));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    lat_mode = 1'b1;
    send_lit(32'd3, 1'b0, 3'd0, 5'd30, 32'h4040_0000, 1'b0);
    drain();
    repeat (10) @(posedge clk);
    #1;

    // 64-bit operand width
    w64(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, 32'h5F80_0000, 1'b1);
    w64(64'h8000_0000_0000_0000, 1'b1, 3'd0, 32'hDF00_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
